act_unit_pipe: RTL and testbench



---
 rtl/act_unit_pipe.sv | 276 +++++++++++++++++++++++++++
 tb/tb_act_unit_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : act_unit_pipe
// Description : Multi-lane, three-stage pipelined activation unit. Every lane
//               of a beat carries an IEEE-754 single-precision sum and receives
//               the same per-beat activation selected by in_mode:
//                 00 pass-through, 01 ReLU, 10 PLAN sigmoid, 11 leaky ReLU.
//               Valid/ready handshake on both sides with full backpressure;
//               each stage advances whenever the stage after it is empty or
//               moving, so bubbles are squeezed out while stalled.
//
// Parameters  : LANES       - number of 32-bit lanes per beat
//               LEAKY_SHIFT - leaky slope is 2^-LEAKY_SHIFT (1..8)
//
// Ports       : clk        in   clock
//               rst        in   synchronous active-high reset
//               in_valid   in   input beat valid
//               in_ready   out  unit can accept a beat
//               in_mode    in   activation select for this beat
//               in_data    in   lane k at bits [32k+31:32k]
//               out_valid  out  output beat valid
//               out_ready  in   downstream accepts the beat
//               out_data   out  activated lanes, same packing as in_data
//
// Build macro : ACT_LEAKY_RELU_EN - when defined, mode 11 is leaky ReLU;
//               when undefined, mode 11 behaves exactly like ReLU and
//               LEAKY_SHIFT has no effect on the datapath.
//
// Revision    : 1.0 - initial release
// ============================================================================
module act_unit_pipe #(
    parameter int LANES       = 4,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic [32*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_data
);

    localparam logic [1:0]  c_MODE_PASS = 2'b00;
    localparam logic [1:0]  c_MODE_SIG  = 2'b10;
    localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;
    // 1.0 in Q1.16
    localparam logic [16:0] c_ONE       = 17'h1_0000;
`ifdef ACT_LEAKY_RELU_EN
    localparam logic [7:0]  c_LEAKY_EXP = 8'(LEAKY_SHIFT);
`endif

    // Slope range guard, evaluated at elaboration only.
    if (LEAKY_SHIFT < 1 || LEAKY_SHIFT > 8) begin : g_bad_leaky_shift
        $error("act_unit_pipe: LEAKY_SHIFT must be in 1..8");
    end

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic                  r_v1, r_v2, r_v3;
    logic [1:0]            r_mode1, r_mode2;
    logic [32*LANES-1:0]   r_data1;
    logic [LANES-1:0]      r_zero1, r_nan1;
    logic [32*LANES-1:0]   r_res2;
    logic [17*LANES-1:0]   r_y2;
    logic [LANES-1:0]      r_nan2;
    logic [32*LANES-1:0]   r_out3;

    logic [LANES-1:0]      w_zero_in, w_nan_in;
    logic [32*LANES-1:0]   w_res2;
    logic [17*LANES-1:0]   w_y2;
    logic [32*LANES-1:0]   w_out3;

    logic w_en1, w_en2, w_en3;

    // A stage may load when its successor is empty or is itself loading.
    assign w_en3    = out_ready || !r_v3;
    assign w_en2    = w_en3 || !r_v2;
    assign w_en1    = w_en2 || !r_v1;
    assign in_ready = w_en1;

    assign out_valid = r_v3;
    assign out_data  = r_out3;

    // ------------------------------------------------------------------------
    // Per-lane datapath
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        // ---- S1: classify the incoming lane ----
        logic [7:0]  w_in_exp;
        logic [22:0] w_in_man;
        assign w_in_exp     = in_data[32*g+23 +: 8];
        assign w_in_man     = in_data[32*g +: 23];
        assign w_zero_in[g] = (w_in_exp == 8'd0);
        assign w_nan_in[g]  = (w_in_exp == 8'hFF) && (w_in_man != 23'd0);

        // ---- S2: fixed-point sigmoid core and sign-based activations ----
        logic [31:0] w_x;
        logic        w_sign;
        logic [7:0]  w_exp;
        logic [22:0] w_man;
        logic [7:0]  w_sh;
        logic [19:0] w_fx;
        logic [16:0] w_ymag;
        logic [16:0] w_y;
        logic [31:0] w_relu;
        logic [31:0] w_res;
`ifdef ACT_LEAKY_RELU_EN
        logic [31:0] w_leaky;
`endif

        assign w_x    = r_data1[32*g +: 32];
        assign w_sign = w_x[31];
        assign w_exp  = w_x[30:23];
        assign w_man  = w_x[22:0];

        always_comb begin
            w_sh   = 8'd134 - w_exp;
            w_fx   = '0;
            w_ymag = '0;
            w_y    = '0;
            w_relu = '0;
            w_res  = '0;
`ifdef ACT_LEAKY_RELU_EN
            w_leaky = '0;
`endif
            // |x| in Q4.16: the hidden-one mantissa weighs 2^(exp-150), so the
            // Q4.16 value is {1,man} >> (134 - exp). exp >= 131 means |x| >= 16
            // (Inf included) and clips.
            if (r_zero1[g]) begin
                w_fx = '0;
            end else if (w_exp >= 8'd131) begin
                w_fx = 20'hF_FFFF;
            end else if (w_sh >= 8'd24) begin
                w_fx = '0;
            end else begin
                w_fx = 20'({1'b1, w_man} >> w_sh);
            end

            // PLAN segments, thresholds 5.0 / 2.375 / 1.0 in Q4.16
            if (w_fx >= 20'h5_0000) begin
                w_ymag = c_ONE;
            end else if (w_fx >= 20'h2_6000) begin
                w_ymag = 17'(w_fx >> 5) + 17'h0_D800;
            end else if (w_fx >= 20'h1_0000) begin
                w_ymag = 17'(w_fx >> 3) + 17'h0_A000;
            end else begin
                w_ymag = 17'(w_fx >> 2) + 17'h0_8000;
            end
            w_y = w_sign ? (c_ONE - w_ymag) : w_ymag;

            // ReLU: any set sign bit (including -0) or a flushed denormal gives +0
            if (r_nan1[g]) begin
                w_relu = c_QNAN;
            end else if (w_sign || r_zero1[g]) begin
                w_relu = '0;
            end else begin
                w_relu = w_x;
            end

`ifdef ACT_LEAKY_RELU_EN
            // Leaky ReLU: scale negatives by 2^-LEAKY_SHIFT via the exponent.
            // -Inf becomes a large finite negative rather than staying Inf.
            if (r_nan1[g]) begin
                w_leaky = c_QNAN;
            end else if (r_zero1[g]) begin
                w_leaky = '0;
            end else if (!w_sign) begin
                w_leaky = w_x;
            end else if (w_exp <= c_LEAKY_EXP) begin
                w_leaky = '0;
            end else begin
                w_leaky = {1'b1, w_exp - c_LEAKY_EXP, w_man};
            end
`endif

            // Sigmoid beats ignore w_res; S3 selects the repacked y instead.
            case (r_mode1)
                c_MODE_PASS: w_res = w_x;
`ifdef ACT_LEAKY_RELU_EN
                2'b11:       w_res = w_leaky;
`else
                2'b11:       w_res = w_relu;
`endif
                default:     w_res = w_relu;
            endcase
        end

        assign w_res2[32*g +: 32] = w_res;
        assign w_y2[17*g +: 17]   = w_y;

        // ---- S3: repack Q1.16 sigmoid result and select lane output ----
        logic [16:0] w_yq;
        logic [4:0]  w_lead;
        logic [7:0]  w_fexp;
        logic [22:0] w_mant;
        logic [31:0] w_o;

        assign w_yq = r_y2[17*g +: 17];

        always_comb begin
            w_lead = '0;
            for (int b = 0; b < 17; b++) begin
                if (w_yq[b]) begin
                    w_lead = 5'(b);
                end
            end
            // Bit w_lead of a Q1.16 value weighs 2^(w_lead-16).
            w_fexp = 8'd111 + {3'b000, w_lead};
            // Shift the leading one out of the top; bits below it become the
            // mantissa (no bits are lost, so truncation is exact here).
            w_mant = {6'b00_0000, w_yq} << (5'd23 - w_lead);

            if (r_mode2 != c_MODE_SIG) begin
                w_o = r_res2[32*g +: 32];
            end else if (r_nan2[g]) begin
                w_o = c_QNAN;
            end else if (w_yq == 17'd0) begin
                w_o = '0;
            end else begin
                w_o = {1'b0, w_fexp, w_mant};
            end
        end

        assign w_out3[32*g +: 32] = w_o;
    end

    // ------------------------------------------------------------------------
    // Control registers (reset) and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_out3 <= '0;
        end else begin
            if (w_en1) begin
                r_v1 <= in_valid;
            end
            if (w_en2) begin
                r_v2 <= r_v1;
            end
            if (w_en3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_out3 <= w_out3;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage data registers; only loaded when a valid beat moves in, so their
    // contents are meaningless whenever the matching valid is low.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_en1 && in_valid) begin
            r_data1 <= in_data;
            r_mode1 <= in_mode;
            r_zero1 <= w_zero_in;
            r_nan1  <= w_nan_in;
        end
        if (w_en2 && r_v1) begin
            r_res2  <= w_res2;
            r_y2    <= w_y2;
            r_nan2  <= r_nan1;
            r_mode2 <= r_mode1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_act_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_unit_pipe
// Description : Directed self-checking bench for act_unit_pipe (LANES=4,
//               LEAKY_SHIFT=3). Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_unit_pipe;

    localparam int LANES = 4;
    localparam int W     = 32 * LANES;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    int checks = 0;
    int errors = 0;

    act_unit_pipe #(
        .LANES       (LANES),
        .LEAKY_SHIFT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_data = '0; out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++; $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sigmoid();
        logic [W-1:0] din  [3];
        logic [W-1:0] dexp [3];
        din[0]  = {32'h40C00000, 32'hBF800000, 32'h3F800000, 32'h00000000};
        dexp[0] = {32'h3F800000, 32'h3E800000, 32'h3F400000, 32'h3F000000};
        din[1]  = {32'h40400000, 32'h7FC00001, 32'h3F000000, 32'hC0C00000};
        dexp[1] = {32'h3F700000, 32'h7FC00000, 32'h3F200000, 32'h00000000};
        din[2]  = {32'h41800000, 32'hFF800000, 32'h7F800000, 32'h00000001};
        dexp[2] = {32'h3F800000, 32'h00000000, 32'h3F800000, 32'h3F000000};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== dexp[i-3]) begin
                    errors++;
                    $display("FAIL sigmoid beat %0d: got valid=%b data=%h want valid=1 data=%h",
                             i-3, out_valid, out_data, dexp[i-3]);
                end
            end
            if (i < 3) begin
                in_valid = 1'b1; in_mode = 2'b10; in_data = din[i];
            end else begin
                in_valid = 1'b0; in_data = '0;
            end
            tick();
        end
    endtask

    task automatic test_relu_pass();
        logic [W-1:0] din  [3];
        logic [W-1:0] dexp [3];
        logic [1:0]   md   [3];
        din[0]  = {32'h7FC00001, 32'h80000000, 32'h40000000, 32'hC0000000};
        dexp[0] = {32'h7FC00000, 32'h00000000, 32'h40000000, 32'h00000000};
        md[0]   = 2'b01;
        din[1]  = din[0];
        dexp[1] = din[0];
        md[1]   = 2'b00;
        din[2]  = {32'h7F800001, 32'h40400000, 32'h80800000, 32'hC0800000};
`ifdef ACT_LEAKY_RELU_EN
        dexp[2] = {32'h7FC00000, 32'h40400000, 32'h00000000, 32'hBF000000};
`else
        dexp[2] = {32'h7FC00000, 32'h40400000, 32'h00000000, 32'h00000000};
`endif
        md[2]   = 2'b11;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== dexp[i-3]) begin
                    errors++;
                    $display("FAIL relu_pass_leaky beat %0d: got valid=%b data=%h want valid=1 data=%h",
                             i-3, out_valid, out_data, dexp[i-3]);
                end
            end
            if (i < 3) begin
                in_valid = 1'b1; in_mode = md[i]; in_data = din[i];
            end else begin
                in_valid = 1'b0; in_data = '0;
            end
            tick();
        end
    endtask

    task automatic test_leaky_latency();
        logic [W-1:0] dexp;
`ifdef ACT_LEAKY_RELU_EN
        dexp = {4{32'hBF000000}};
`else
        dexp = '0;
`endif
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 2'b11; in_data = {4{32'hC0800000}};
        tick();
        in_valid = 1'b0; in_data = '0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL latency_edge1: got valid=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL latency_edge2: got valid=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== dexp) begin
            errors++;
            $display("FAIL leaky_edge3: got valid=%b data=%h want valid=1 data=%h",
                     out_valid, out_data, dexp);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] beats [10];
        logic [1:0]   modes [10];
        logic [W-1:0] prev_data;
        int tx, rx;
        bit saw_block, prev_stall;
        tx = 0; rx = 0; saw_block = 1'b0; prev_stall = 1'b0; prev_data = '0;
        // Even beats: negative values in pass mode; odd beats: positive values
        // in ReLU mode. Both must come back unchanged and in order.
        for (int b = 0; b < 10; b++) begin
            modes[b] = (b % 2 == 0) ? 2'b00 : 2'b01;
            for (int l = 0; l < LANES; l++) begin
                beats[b][32*l +: 32] = {(b % 2 == 0), 31'h40000000 + 31'(b*16 + l)};
            end
        end
        for (int c = 0; c < 60 && rx < 10; c++) begin
            out_ready = !(c >= 6 && c <= 10);
            if (tx < 10) begin
                in_valid = 1'b1; in_mode = modes[tx]; in_data = beats[tx];
            end else begin
                in_valid = 1'b0; in_data = '0;
            end
            #1;
            if (c < 6) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL bp_in_ready_early c=%0d: got %b want 1", c, in_ready);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL bp_stall_hold c=%0d: got valid=%b data=%h want valid=1 data=%h",
                             c, out_valid, out_data, prev_data);
                end
            end
            if (c >= 11) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_throughput c=%0d: got valid=%b want 1", c, out_valid);
                end
            end
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== beats[rx]) begin
                    errors++;
                    $display("FAIL bp_order beat %0d: got %h want %h", rx, out_data, beats[rx]);
                end
                rx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) tx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        checks++;
        if (rx != 10) begin
            errors++; $display("FAIL bp_count: got %0d beats want 10", rx);
        end
        checks++;
        if (!saw_block) begin
            errors++; $display("FAIL bp_in_ready_fall: got never-low want low-while-full");
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_duplicate: got valid=%b want 0", out_valid);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = 2'b00; in_data = {4{32'h40000000}} + W'(i);
            tick();
        end
        // Three beats in flight; hold output stalled and reset.
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++; $display("FAIL rst_mid_out_data: got %h want 0", out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL rst_mid_stale cycle %0d: got valid=%b want 0", i, out_valid);
            end
        end
        in_valid = 1'b1; in_mode = 2'b01; in_data = {4{32'h3F800000}};
        tick();
        in_valid = 1'b0; in_data = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_early: got valid=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== {4{32'h3F800000}}) begin
            errors++;
            $display("FAIL rst_mid_next_beat: got valid=%b data=%h want valid=1 data=%h",
                     out_valid, out_data, {4{32'h3F800000}});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_sigmoid();
        test_relu_pass();
        test_leaky_latency();
        test_backpressure();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
